// File: rtl/fir_pkg.sv
// Shared state encoding, default widths and address-wrap helper for the
// FIR MAC sequencer.
package fir_pkg;

    localparam int W_IN_DEF  = 16;
    localparam int W_C_DEF   = 18;
    localparam int AW_DEF    = 4;
    localparam int NTAPS_DEF = 16;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // (a - b) mod n for a, b < n; n need not be a power of two
    function automatic int unsigned mod_dec(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned n);
        return (a >= b) ? (a - b) : (a + n - b);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-source and MAC/RAM/ROM datapath signals of the FIR sequencer.
// master = sequencer, slave = sample source plus datapath.
interface fir_mac_sequencer_if #(
    parameter int Win = fir_pkg::W_IN_DEF,
    parameter int Wc  = fir_pkg::W_C_DEF,
    parameter int AW  = fir_pkg::AW_DEF
);
    logic              din_valid;
    logic [Win-1:0]    din;
    logic              ready;
    logic              overrun;
    logic              smp_we;
    logic [AW-1:0]     smp_waddr;
    logic [Win-1:0]    smp_wdata;
    logic [AW-1:0]     smp_raddr;
    logic [AW-1:0]     coef_addr;
    logic              mac_rst;
    logic              mac_ce;
    logic [Win+Wc-1:0] mac_dout;
    logic [Win+Wc-1:0] dout;
    logic              dout_valid;

    modport master (
        input  din_valid, din, mac_dout,
        output ready, overrun, smp_we, smp_waddr, smp_wdata, smp_raddr,
               coef_addr, mac_rst, mac_ce, dout, dout_valid
    );

    modport slave (
        output din_valid, din, mac_dout,
        input  ready, overrun, smp_we, smp_waddr, smp_wdata, smp_raddr,
               coef_addr, mac_rst, mac_ce, dout, dout_valid
    );
endinterface

// File: rtl/fir_addr_gen.sv
// Circular sample-buffer pointers and tap counter; read address walks
// backwards from the newest sample with an explicit wrap at NTAPS.
module fir_addr_gen
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept_i,
    input  logic          step_i,
    output logic [AW-1:0] wptr_o,
    output logic [AW-1:0] k_o,
    output logic          k_last_o,
    output logic [AW-1:0] raddr_o
);
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] newest_q, newest_d;
    logic [AW-1:0] k_q, k_d;

    always_comb begin
        wptr_d   = wptr_q;
        newest_d = newest_q;
        k_d      = k_q;
        if (accept_i) begin
            newest_d = wptr_q;
            wptr_d   = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            k_d      = '0;
        end else if (step_i) begin
            k_d = (k_q == LAST) ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            newest_q <= '0;
            k_q      <= '0;
        end else begin
            wptr_q   <= wptr_d;
            newest_q <= newest_d;
            k_q      <= k_d;
        end
    end

    assign wptr_o   = wptr_q;
    assign k_o      = k_q;
    assign k_last_o = (k_q == LAST);
    assign raddr_o  = AW'(mod_dec(32'(newest_q), 32'(k_q), NTAPS));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexes one MAC over NTAPS taps per accepted sample and
// registers the finished accumulator as the filter output.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int Win   = W_IN_DEF,
    parameter int Wc    = W_C_DEF,
    parameter int NTAPS = NTAPS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_mac_sequencer_if.master  bus
);
    state_e            state_q, state_d;
    logic              issue_q, issue_d;
    logic              overrun_q, overrun_d;
    logic              dout_valid_q;
    logic [Win+Wc-1:0] dout_q;

    logic              accept, step, k_last;
    logic [AW-1:0]     wptr, k, raddr;

    fir_addr_gen #(.NTAPS(NTAPS), .AW(AW)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept),
        .step_i   (step),
        .wptr_o   (wptr),
        .k_o      (k),
        .k_last_o (k_last),
        .raddr_o  (raddr)
    );

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        step          = 1'b0;
        issue_d       = 1'b0;
        bus.ready     = 1'b0;
        bus.smp_we    = 1'b0;
        bus.smp_waddr = wptr;
        bus.smp_wdata = bus.din;
        bus.smp_raddr = raddr;
        bus.coef_addr = k;
        bus.mac_rst   = 1'b0;
        bus.mac_ce    = issue_q;
        // reset aborts combinationally so a mid-run reset never lets a product land
        if (rst) begin
            bus.mac_rst = 1'b1;
            bus.mac_ce  = 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    bus.smp_we    = 1'b1;
                    bus.smp_waddr = k;
                    bus.smp_wdata = '0;
                    bus.mac_rst   = 1'b1;
                    step          = 1'b1;
                    if (k_last) state_d = S_IDLE;
                end
                S_IDLE: begin
                    bus.ready = 1'b1;
                    if (bus.din_valid) begin
                        bus.smp_we  = 1'b1;
                        bus.mac_rst = 1'b1;
                        accept      = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                S_RUN: begin
                    step    = 1'b1;
                    issue_d = 1'b1;
                    if (k_last) state_d = S_DRAIN;
                end
                S_DRAIN: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_CLEAR;
            endcase
        end
        overrun_d = overrun_q | (bus.din_valid & ~bus.ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            issue_q      <= 1'b0;
            overrun_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            overrun_q    <= overrun_d;
            dout_valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) dout_q <= bus.mac_dout;
        end
    end

    assign bus.overrun    = overrun_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: a 16-tap and a 5-tap sequencer, each wrapped in a
// behavioural sample RAM, coefficient ROM and MAC.
module tb_fir_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic junk = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_sequencer_if #(.Win(16), .Wc(18), .AW(4)) b16 ();
    fir_mac_sequencer_if #(.Win(16), .Wc(18), .AW(3)) b5 ();

    fir_mac_sequencer #(.Win(16), .Wc(18), .NTAPS(16), .AW(4)) dut16 (
        .clk (clk), .rst (rst), .bus (b16)
    );
    fir_mac_sequencer #(.Win(16), .Wc(18), .NTAPS(5), .AW(3)) dut5 (
        .clk (clk), .rst (rst), .bus (b5)
    );

    // datapath models: 1-cycle RAM/ROM reads feeding an accumulator
    logic [15:0] ram16 [16];
    logic [17:0] rom16 [16];
    logic [15:0] rd16;
    logic [17:0] cq16;
    logic [33:0] acc16;
    logic [15:0] ram5 [8];
    logic [17:0] rom5 [8];
    logic [15:0] rd5;
    logic [17:0] cq5;
    logic [33:0] acc5;

    always @(posedge clk) begin
        if (junk) begin
            for (int i = 0; i < 16; i++) ram16[i] <= 16'h7777;
            for (int i = 0; i < 8; i++)  ram5[i]  <= 16'h7777;
        end else begin
            if (b16.smp_we) ram16[b16.smp_waddr] <= b16.smp_wdata;
            if (b5.smp_we)  ram5[b5.smp_waddr]   <= b5.smp_wdata;
        end
        rd16 <= ram16[b16.smp_raddr];
        cq16 <= rom16[b16.coef_addr];
        rd5  <= ram5[b5.smp_raddr];
        cq5  <= rom5[b5.coef_addr];
        if (b16.mac_rst) acc16 <= '0;
        else if (b16.mac_ce) acc16 <= acc16 + 34'(rd16) * 34'(cq16);
        if (b5.mac_rst) acc5 <= '0;
        else if (b5.mac_ce) acc5 <= acc5 + 34'(rd5) * 34'(cq5);
    end
    assign b16.mac_dout = acc16;
    assign b5.mac_dout  = acc5;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    // monitors: latency, output value, MAC control timing, address range
    int          acc16_q[$], acc5_q[$];
    logic [33:0] exp16_q[$], exp5_q[$];
    int          last_acc16 = 0, ce16_start = 0, dv16 = 0, dv5 = 0;
    int          bad5 = 0, wrap5 = 0;
    logic        ce16_prev = 1'b0;
    logic [2:0]  prev5 = 3'd0;

    always @(negedge clk) begin
        if (rst) begin
            acc16_q.delete();
            acc5_q.delete();
            ce16_prev = 1'b0;
        end else begin
            if (b16.din_valid && b16.ready) begin
                acc16_q.push_back(cyc);
                last_acc16 = cyc;
                chk("t0_mac_rst", b16.mac_rst, 1);
                chk("t0_smp_we", b16.smp_we, 1);
            end
            if (b16.mac_rst && b16.mac_ce) chk("rst_ce_overlap", 1, 0);
            if (b16.mac_ce && !ce16_prev) ce16_start = cyc;
            if (!b16.mac_ce && ce16_prev) begin
                chk("ce_len", cyc - ce16_start, 16);
                chk("ce_start", ce16_start - last_acc16, 2);
            end
            ce16_prev = b16.mac_ce;
            if (b16.dout_valid) begin
                dv16++;
                if (acc16_q.size() == 0 || exp16_q.size() == 0) chk("dv16_spurious", 1, 0);
                else begin
                    chk("lat16", cyc - acc16_q.pop_front(), 19);
                    chk("dout16", b16.dout, exp16_q.pop_front());
                end
            end
            if (b5.din_valid && b5.ready) acc5_q.push_back(cyc);
            if (b5.smp_raddr > 3'd4) bad5++;
            if (prev5 == 3'd0 && b5.smp_raddr == 3'd4) wrap5++;
            prev5 = b5.smp_raddr;
            if (b5.dout_valid) begin
                dv5++;
                if (acc5_q.size() == 0 || exp5_q.size() == 0) chk("dv5_spurious", 1, 0);
                else begin
                    chk("lat5", cyc - acc5_q.pop_front(), 8);
                    chk("dout5", b5.dout, exp5_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [15:0] d);
        int n = 0;
        while (!b16.ready && n < 200) begin idle(1); n++; end
        if (n >= 200) chk("ready16_timeout", 0, 1);
        b16.din = d;
        b16.din_valid = 1'b1;
        idle(1);
        b16.din_valid = 1'b0;
    endtask

    task automatic send5(input logic [15:0] d);
        int n = 0;
        while (!b5.ready && n < 200) begin idle(1); n++; end
        if (n >= 200) chk("ready5_timeout", 0, 1);
        b5.din = d;
        b5.din_valid = 1'b1;
        idle(1);
        b5.din_valid = 1'b0;
    endtask

    logic [33:0] ramp_exp [12] = '{1, 3, 6, 10, 15, 20, 25, 30, 35, 40, 45, 50};

    initial begin
        int n16, n5, n, na, nz;
        int acc_cyc [4];
        b16.din_valid = 1'b0; b16.din = '0;
        b5.din_valid  = 1'b0; b5.din  = '0;
        for (int i = 0; i < 16; i++) rom16[i] = 18'd2;
        for (int i = 0; i < 8; i++)  rom5[i]  = 18'd1;
        junk = 1'b1;
        idle(3);
        junk = 1'b0;

        chk("rst_ready", b16.ready, 0);
        chk("rst_mac_rst", b16.mac_rst, 1);
        chk("rst_mac_ce", b16.mac_ce, 0);
        chk("rst_smp_we", b16.smp_we, 0);
        chk("rst_dout", b16.dout, 0);
        chk("rst_dout_valid", b16.dout_valid, 0);
        chk("rst_overrun", b16.overrun, 0);
        chk("rst_addrs", {b16.smp_waddr, b16.smp_raddr, b16.coef_addr}, 0);

        rst = 1'b0;
        n16 = -1; n5 = -1;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (b16.ready && n16 < 0) n16 = i;
            if (b5.ready && n5 < 0) n5 = i;
        end
        chk("clear16_len", n16, 16);
        chk("clear5_len", n5, 5);
        nz = 0;
        for (int i = 0; i < 16; i++) if (ram16[i] != 16'd0) nz++;
        for (int i = 0; i < 5; i++)  if (ram5[i] != 16'd0) nz++;
        chk("clear_zeroed", nz, 0);

        // stale pre-reset contents must not reach the sum
        exp16_q.push_back(34'd200);
        send16(16'd100);
        idle(25);

        // abort mid-run at k=7
        for (int i = 0; i < 16; i++) rom16[i] = 18'(i + 1);
        send16(16'd1);
        n = 0;
        while (b16.coef_addr != 4'd7 && n < 50) begin idle(1); n++; end
        chk("midrun_k7", b16.coef_addr, 7);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n16 = -1;
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (b16.ready && n16 < 0) n16 = i;
        end
        chk("reclear16_len", n16, 16);
        nz = 0;
        for (int i = 0; i < 16; i++) if (ram16[i] != 16'd0) nz++;
        chk("reclear_zeroed", nz, 0);
        chk("overrun_after_rst", b16.overrun, 0);

        // impulse: outputs walk the coefficient table
        for (int i = 0; i < 16; i++) begin
            exp16_q.push_back(34'(i + 1));
            send16((i == 0) ? 16'd1 : 16'd0);
        end
        idle(25);

        // back-to-back: din_valid held high
        chk("overrun_pre_b2b", b16.overrun, 0);
        exp16_q.push_back(34'd1);
        exp16_q.push_back(34'd3);
        exp16_q.push_back(34'd6);
        exp16_q.push_back(34'd10);
        b16.din = 16'd1;
        b16.din_valid = 1'b1;
        na = 0; n = 0;
        while (na < 4 && n < 200) begin
            @(negedge clk);
            if (b16.ready) begin acc_cyc[na] = cyc; na++; end
            idle(1);
            n++;
        end
        b16.din_valid = 1'b0;
        chk("b2b_accepts", na, 4);
        for (int i = 0; i < 3; i++) chk("b2b_gap", acc_cyc[i+1] - acc_cyc[i], 19);
        idle(25);
        chk("overrun_sticky", b16.overrun, 1);

        // 5-tap ramp with pointer wrap
        for (int i = 1; i <= 12; i++) begin
            exp5_q.push_back(ramp_exp[i-1]);
            send5(16'(i));
        end
        idle(20);

        chk("dv16_count", dv16, 21);
        chk("dv5_count", dv5, 12);
        chk("exp16_left", exp16_q.size(), 0);
        chk("exp5_left", exp5_q.size(), 0);
        chk("raddr5_range", bad5, 0);
        chk("raddr5_wrap", (wrap5 > 0), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Controller that time-multiplexes one multiply-accumulate unit (Win-bit sample × Wc-bit coefficient, Win+Wc-bit accumulator with sync clear and enable) to compute one NTAPS-tap FIR output per accepted input sample. It owns the circular sample-buffer write/read pointers and the coefficient ROM address, and drives the MAC clear and enable. It also registers the final accumulator value as the filter output. It sits between the sample source and the MAC/RAM/ROM datapath of the FIR.

Parameters:
Win, 16, sample width (buffer data, din)
Wc, 18, coefficient width (MAC input only; sizes mac_dout)
NTAPS, 16, number of taps, 2..2**AW
AW, 4, address width of sample RAM and coefficient ROM

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
din_valid  in  1  new sample present this cycle
din  in  Win  input sample
ready  out  1  controller idle, sample accepted if din_valid
overrun  out  1  sticky: din_valid seen while ready=0
smp_we  out  1  sample RAM write enable
smp_waddr  out  AW  sample RAM write address
smp_wdata  out  Win  sample RAM write data (din, or 0 during CLEAR)
smp_raddr  out  AW  sample RAM read address (1-cycle read latency)
coef_addr  out  AW  coefficient ROM address (1-cycle read latency)
mac_rst  out  1  MAC accumulator clear
mac_ce  out  1  MAC accumulate enable
mac_dout  in  Win+Wc  MAC accumulator value
dout  out  Win+Wc  registered filter output
dout_valid  out  1  one-cycle pulse, dout valid

Behaviour:
- States: CLEAR, IDLE, RUN, DRAIN, DONE.
- Reset: state=CLEAR, wptr=0, k=0, ready=0, mac_ce=0, mac_rst=1, smp_we=0, dout=0, dout_valid=0, overrun=0, all addresses 0.
- CLEAR: for NTAPS cycles, smp_we=1, smp_waddr=k, smp_wdata=0, with k running 0..NTAPS-1. Then go to IDLE, wptr=0.
- IDLE: ready=1.
  - On din_valid (cycle t0): smp_we=1, smp_waddr=wptr, smp_wdata=din, mac_rst=1.
  - Latch newest=wptr, then wptr <- (wptr==NTAPS-1)?0:wptr+1, k=0, go to RUN.
- RUN (t1..tNTAPS): coef_addr=k, smp_raddr=(newest-k) mod NTAPS, with explicit wrap from 0 to NTAPS-1 (no reliance on a power of two). k increments each cycle. After issuing k=NTAPS-1, go to DRAIN.
- mac_ce is the issue-valid signal delayed one cycle. It is high exactly NTAPS cycles, t2..t(NTAPS+1); never high in the same cycle as mac_rst.
- DRAIN (t(NTAPS+1)): final product accumulates. Go to DONE.
- DONE (t(NTAPS+2)): dout <= mac_dout. Go to IDLE.
- dout_valid=1 in cycle t0+NTAPS+3 only; dout holds its value until the next capture.
- Latency from accepted sample to dout_valid: NTAPS+3 cycles. Max throughput: one sample per NTAPS+3 cycles.
- ready=0 outside IDLE. din_valid with ready=0 drops the sample (no write, pointer unchanged) and sets overrun; overrun clears only on rst.
- din_valid on the IDLE→RUN transition cycle after DONE is accepted normally (back-to-back).
- rst mid-RUN or mid-CLEAR: abort immediately, no dout_valid, re-enter CLEAR (buffer re-zeroed).
- Widths: addresses AW bits; k counts 0..NTAPS-1; no arithmetic on data. The MAC owns the full-precision Win+Wc accumulation.

Decomposition:
- Shared package fir_pkg: state enum; widths Win, Wc, AW; default NTAPS; a modulo-decrement function for address wrap.
- One natural sub-module: fir_addr_gen (wptr, newest, k, wrapped read address). The FSM and output register stay in the top block.

Test Plan:
- Impulse: NTAPS=16, coefs c[i]=i+1, din=1 then 15 zeros → successive dout = 1,2,...,16, each dout_valid exactly 19 cycles after its sample was accepted.
- Ramp/wrap: NTAPS=5 (AW=3), coefs all 1, din 1..12 spaced 8 cycles apart → dout = 1,3,6,10,15,20,25,...,50. Check smp_raddr wraps 0→4, never 5..7.
- Back-to-back: din_valid held high continuously → exactly one sample accepted per 19 cycles; overrun=1 after the first rejected sample; no accepted sample lost.
- MAC control: check mac_rst at t0, mac_ce high exactly NTAPS consecutive cycles starting t0+2, and mac_rst/mac_ce never both high.
- Reset mid-run: rst in RUN at k=7 → no dout_valid; CLEAR writes 0 to all NTAPS addresses; ready rises NTAPS cycles after rst deasserts; next impulse reproduces the impulse-test outputs.
- Post-reset zeros: immediately after CLEAR, din=100 with coefs all 2 → dout=200 (stale buffer contents must not contribute).
